alu_sequencer: RTL
==================

Name: alu_sequencer

Overview:
Multi-cycle controller that sequences the 8-bit combinational ALU (3-bit function select; N/V/Z flags) for simple register-level commands.
- Owns a small register file and the condition-code register (CCR).
- Accepts one command at a time over a valid/ready handshake.
- Drives the ALU operand and function ports, captures the result, writes it back and updates the flags.
- Sits between the command source (test bench or future decoder) and the ALU instance, which lives at the parent level.

Parameters:
REG_AW, 2, register-file address width; register file holds 2**REG_AW entries of 8 bits.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer can accept a command (high only in IDLE)
cmd_kind  in  2  0=ALU reg-reg, 1=ALU reg-imm (B=cmd_imm), 2=LDI (rd<=imm), 3=reserved (NOP)
cmd_f  in  3  ALU function: 0 ADD, 1 SUB, 2 LSL, 3 LSR, 4 XOR, 5 COM, 6 NEG, 7 CLR
cmd_rd  in  REG_AW  destination register
cmd_rs  in  REG_AW  source A register
cmd_rt  in  REG_AW  source B register (kind 0 only)
cmd_imm  in  8  immediate operand
alu_a  out  8  ALU operand A (registered)
alu_b  out  8  ALU operand B (registered)
alu_f  out  3  ALU function select (registered)
alu_y  in  8  ALU result
alu_n  in  1  ALU negative flag
alu_v  in  1  ALU overflow flag
alu_z  in  1  ALU zero flag
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse in the cycle after writeback commits
ccr  out  3  {N,V,Z}
dbg_addr  in  REG_AW  debug read address
dbg_data  out  8  combinational read of regfile[dbg_addr]

Behaviour:
- Reset state: FSM=IDLE; all registers=0; ccr=0; alu_a=alu_b=0; alu_f=7 (CLR); done=0; busy=0; cmd_ready=1 on the first cycle after reset.
- FSM states: IDLE, OPER, EXEC, WB.
- IDLE:
  - cmd_valid && cmd_ready latches the command.
  - Kind 2 (LDI) goes straight to WB.
  - Kind 3 (NOP) stays in IDLE and pulses done next cycle; regs and CCR unchanged.
  - Kinds 0/1 go to OPER.
- OPER:
  - alu_a <= reg[rs].
  - alu_b <= reg[rt] for kind 0, or cmd_imm for kind 1.
  - alu_f <= cmd_f.
  - Next state EXEC.
- EXEC: ALU output settles combinationally; result_q <= alu_y and flags_q <= {alu_n,alu_v,alu_z}. Next state WB.
- WB:
  - reg[rd] <= result_q, or imm for LDI.
  - ccr <= flags_q for ALU kinds; LDI leaves ccr unchanged.
  - Next state IDLE; done=1 in the following cycle.
- Latency, handshake cycle = T0:
  - ALU command: done at T0+4; new command accepted at T0+4 at the earliest.
  - LDI: done at T0+2.
- cmd_ready is low throughout OPER/EXEC/WB. cmd_valid held high during busy is ignored, not queued.
- Operands are read in OPER, so rs/rt equal to rd of the previous command sees the committed value (no hazard).
- rd==rs==rt is legal; the write uses the result, the read uses the old value.
- Any reg-file width mismatch is impossible: all arithmetic widths are owned by the ALU. The sequencer never modifies alu_y.
- rst asserted in any state: next edge returns to IDLE, regfile and ccr cleared, no partial write, no done pulse.
- dbg_data reflects a write in the cycle after WB.

Optional Feature:
ALU_SEQ_OVF_TRAP_EN
- Defined:
  - Adds output trap (1 bit, reset 0).
  - In WB for an ALU kind with flags_q V=1: reg[rd] is NOT written, ccr IS updated, trap sets to 1 and stays sticky.
  - While trap=1, cmd_ready stays low until rst.
- Undefined: no trap port; overflowing results are written normally.

Decomposition:
- Shared header alu_defs.vh holds:
  - ALU function codes (ALU_ADD..ALU_CLR).
  - cmd_kind codes.
  - FSM state encodings.
  - CCR bit indices (CCR_N=2, CCR_V=1, CCR_Z=0).
- One natural sub-module: seq_regfile. It has 2**REG_AW x 8, two combinational read ports plus a debug read port, and one synchronous write port with synchronous reset clear.

Test Plan:
- Reset then LDI r0=0x7F, LDI r1=0x01 -> each shows done 2 cycles after accept; dbg r0=0x7F, r1=0x01; ccr=000.
- ADD rd=2 rs=0 rt=1 -> alu_a=0x7F, alu_b=0x01, alu_f=0 in EXEC; r2=0x80; ccr={1,1,0}; done at T0+4. With ALU_SEQ_OVF_TRAP_EN: r2 unchanged (0x00), trap=1, cmd_ready stays 0.
- SUB rd=3 rs=1 rt=1 -> r3=0x00, ccr={0,0,1}.
- XOR imm: kind=1, f=4, rs=0 (0x7F), imm=0xFF -> r0=0x80, ccr={1,0,0}. Then NEG r0 -> 0x80, ccr={1,1,0}.
- Second cmd_valid held high during busy -> accepted only at T0+4; exactly one done per command; NOP gives done 1 cycle later with ccr unchanged.
- Assert rst during EXEC of ADD targeting r2=0x55 -> next cycle IDLE, r2=0x00, ccr=000, no done pulse.

Source files
------------

// File: rtl/alu_sequencer_pkg.sv
// rtl/alu_sequencer_pkg.sv - shared ALU function codes, command kinds, FSM states and CCR bit indices
package alu_sequencer_pkg;

    // ALU function select codes, as driven on alu_f
    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_LSL = 3'd2,
        ALU_LSR = 3'd3,
        ALU_XOR = 3'd4,
        ALU_COM = 3'd5,
        ALU_NEG = 3'd6,
        ALU_CLR = 3'd7
    } alu_f_t;

    // Command kinds carried on cmd_kind
    typedef enum logic [1:0] {
        KIND_RR  = 2'd0,
        KIND_RI  = 2'd1,
        KIND_LDI = 2'd2,
        KIND_NOP = 2'd3
    } kind_t;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OPER = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_t;

    // Bit positions inside the {N,V,Z} condition-code register
    localparam int CCR_N = 2;
    localparam int CCR_V = 1;
    localparam int CCR_Z = 0;

endpackage

// File: rtl/alu_sequencer_regfile.sv
// rtl/alu_sequencer_regfile.sv - seq_regfile: 2**AW x 8 register file, two read ports, debug read, one write port
module seq_regfile #(
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr_a,
    output logic [7:0]    rdata_a,
    input  logic [AW-1:0] raddr_b,
    output logic [7:0]    rdata_b,
    input  logic [AW-1:0] dbg_addr,
    output logic [7:0]    dbg_data
);

    localparam int DEPTH = 1 << AW;

    logic [7:0] mem [DEPTH];

    // Synchronous write; reset clears every entry
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a  = mem[raddr_a];
    assign rdata_b  = mem[raddr_b];
    assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - multi-cycle ALU command sequencer; optional sticky overflow trap under ALU_SEQ_OVF_TRAP_EN
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int REG_AW = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_kind,
    input  logic [2:0]        cmd_f,
    input  logic [REG_AW-1:0] cmd_rd,
    input  logic [REG_AW-1:0] cmd_rs,
    input  logic [REG_AW-1:0] cmd_rt,
    input  logic [7:0]        cmd_imm,
    output logic [7:0]        alu_a,
    output logic [7:0]        alu_b,
    output logic [2:0]        alu_f,
    input  logic [7:0]        alu_y,
    input  logic              alu_n,
    input  logic              alu_v,
    input  logic              alu_z,
    output logic              busy,
    output logic              done,
    output logic [2:0]        ccr,
`ifdef ALU_SEQ_OVF_TRAP_EN
    output logic              trap,
`endif
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [7:0]        dbg_data
);

    state_t            state_q, state_d;
    kind_t             kind_q;
    logic [2:0]        f_q;
    logic [REG_AW-1:0] rd_q, rs_q, rt_q;
    logic [7:0]        imm_q;
    logic [7:0]        result_q;
    logic [2:0]        flags_q;
    logic [7:0]        rdata_a, rdata_b, wdata;
    logic              accept, alu_kind_q, we, trap_q;

    assign cmd_ready  = (state_q == ST_IDLE) && !trap_q;
    assign busy       = (state_q != ST_IDLE);
    assign accept     = cmd_valid && cmd_ready;
    assign alu_kind_q = (kind_q == KIND_RR) || (kind_q == KIND_RI);
    assign wdata      = (kind_q == KIND_LDI) ? imm_q : result_q;

`ifdef ALU_SEQ_OVF_TRAP_EN
    logic wb_ovf;
    assign wb_ovf = alu_kind_q && flags_q[CCR_V];
    assign we     = (state_q == ST_WB) && !wb_ovf;
    assign trap   = trap_q;

    // Sticky trap: an overflowing ALU writeback blocks further commands until reset
    always_ff @(posedge clk) begin
        if (rst) begin
            trap_q <= 1'b0;
        end else if ((state_q == ST_WB) && wb_ovf) begin
            trap_q <= 1'b1;
        end
    end
`else
    assign we     = (state_q == ST_WB);
    assign trap_q = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: LDI skips the ALU, NOP never leaves IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (kind_t'(cmd_kind))
                        KIND_LDI: state_d = ST_WB;
                        KIND_NOP: state_d = ST_IDLE;
                        default:  state_d = ST_OPER;
                    endcase
                end
            end
            ST_OPER: state_d = ST_EXEC;
            ST_EXEC: state_d = ST_WB;
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Latch the command fields on the accepting handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            kind_q <= KIND_NOP;
            f_q    <= 3'd0;
            rd_q   <= '0;
            rs_q   <= '0;
            rt_q   <= '0;
            imm_q  <= 8'h00;
        end else if (accept) begin
            kind_q <= kind_t'(cmd_kind);
            f_q    <= cmd_f;
            rd_q   <= cmd_rd;
            rs_q   <= cmd_rs;
            rt_q   <= cmd_rt;
            imm_q  <= cmd_imm;
        end
    end

    // Register the ALU operands in OPER so reads see the last committed write
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a <= 8'h00;
            alu_b <= 8'h00;
            alu_f <= ALU_CLR;
        end else if (state_q == ST_OPER) begin
            alu_a <= rdata_a;
            alu_b <= (kind_q == KIND_RI) ? imm_q : rdata_b;
            alu_f <= f_q;
        end
    end

    // Capture the settled ALU result and flags in EXEC
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= 8'h00;
            flags_q  <= 3'b000;
        end else if (state_q == ST_EXEC) begin
            result_q       <= alu_y;
            flags_q[CCR_N] <= alu_n;
            flags_q[CCR_V] <= alu_v;
            flags_q[CCR_Z] <= alu_z;
        end
    end

    // CCR update on ALU writeback; done pulses the cycle after WB or after a NOP accept
    always_ff @(posedge clk) begin
        if (rst) begin
            ccr  <= 3'b000;
            done <= 1'b0;
        end else begin
            done <= (state_q == ST_WB) || (accept && (cmd_kind == KIND_NOP));
            if ((state_q == ST_WB) && alu_kind_q) begin
                ccr <= flags_q;
            end
        end
    end

    seq_regfile #(
        .AW (REG_AW)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we       (we),
        .waddr    (rd_q),
        .wdata    (wdata),
        .raddr_a  (rs_q),
        .rdata_a  (rdata_a),
        .raddr_b  (rt_q),
        .rdata_b  (rdata_b),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

endmodule
